// File: rtl/range_ctrl_pkg.sv
// range_ctrl_pkg: shared types and default sizing for the range sequencer.
//   state_t            - sequencer state encoding
//   RAM_WORDS_DEF      - default number of result words
//   ADDR_BITS_DEF      - default RAM read address width
//   TIMEOUT_CYCLES_DEF - default BUSY watchdog limit
package range_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2,
    BROWSE = 2'd3
  } state_t;

  localparam int RAM_WORDS_DEF      = 256;
  localparam int ADDR_BITS_DEF      = 8;
  localparam int TIMEOUT_CYCLES_DEF = 2**24;
endpackage

// File: rtl/range_ctrl_press_repeat.sv
// press_repeat: rising-edge detector for a debounced button, with an optional
// hold/auto-repeat timer when RANGE_CTRL_AUTO_REPEAT_EN is defined.
//   clk, reset - clock, synchronous active-high reset
//   lvl_i      - debounced button level
//   clr_i      - holds the repeat timer in its cleared state
//   step_o     - one-cycle step request (combinational, consumed at the next edge)
// The previous-level register resets to 1 so a button held through reset has
// to be released and pressed again before it produces a step.
module press_repeat #(
  parameter bit REPEAT_EN     = 1'b0,
  parameter int HOLD_CYCLES   = 10,
  parameter int REPEAT_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic lvl_i,
  input  logic clr_i,
  output logic step_o
);
  logic prev_q;
  logic edge_w;

  always_ff @(posedge clk) begin
    if (reset) prev_q <= 1'b1;
    else       prev_q <= lvl_i;
  end

  assign edge_w = lvl_i & ~prev_q;

`ifdef RANGE_CTRL_AUTO_REPEAT_EN
  localparam int CW = $clog2(HOLD_CYCLES + REPEAT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          rep_q, rep_d;
  logic          run_w, tick_w;

  // cnt_q holds the number of cycles since the press (first phase) or since
  // the last repeat step (repeat phase); the press edge itself sees cnt_q=0.
  assign run_w  = REPEAT_EN && lvl_i && !clr_i;
  assign tick_w = run_w && (rep_q ? (cnt_q == CW'(REPEAT_CYCLES))
                                  : (cnt_q == CW'(HOLD_CYCLES)));

  always_comb begin
    cnt_d = cnt_q;
    rep_d = rep_q;
    if (!run_w) begin
      cnt_d = '0;
      rep_d = 1'b0;
    end else if (tick_w) begin
      cnt_d = CW'(1);
      rep_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      rep_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rep_q <= rep_d;
    end
  end

  assign step_o = edge_w | tick_w;
`else
  localparam int unused_cfg = HOLD_CYCLES + REPEAT_CYCLES + int'(REPEAT_EN);
  logic unused_clr;
  assign unused_clr = clr_i;
  assign step_o     = edge_w;
`endif
endmodule

// File: rtl/range_ctrl.sv
// range_ctrl: launches the Collatz range engine from a go press, waits for
// completion under a watchdog, then lets the user browse the result RAM.
// Optional feature macro: RANGE_CTRL_AUTO_REPEAT_EN (auto-repeat on inc/dec).
//   clk, reset        - clock, synchronous active-high reset
//   sw_start          - start value from switches
//   btn_go/inc/dec/home - debounced button levels
//   range_done        - completion from range engine (honoured only in BUSY)
//   range_go          - one-cycle launch strobe
//   range_start       - latched base value
//   range_addr        - RAM read index
//   disp_n            - base + index (combinational)
//   busy/ready/error  - status flags
module range_ctrl
  import range_ctrl_pkg::*;
#(
  parameter int RAM_WORDS      = RAM_WORDS_DEF,
  parameter int ADDR_BITS      = ADDR_BITS_DEF,
  parameter int START_BITS     = 32,
  parameter int HOLD_CYCLES    = 25_000_000,
  parameter int REPEAT_CYCLES  = 5_000_000,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [START_BITS-1:0] sw_start,
  input  logic                  btn_go,
  input  logic                  btn_inc,
  input  logic                  btn_dec,
  input  logic                  btn_home,
  input  logic                  range_done,
  output logic                  range_go,
  output logic [START_BITS-1:0] range_start,
  output logic [ADDR_BITS-1:0]  range_addr,
  output logic [START_BITS-1:0] disp_n,
  output logic                  busy,
  output logic                  ready,
  output logic                  error
);
  localparam int                   WW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_BITS-1:0] IDX_MAX = ADDR_BITS'(RAM_WORDS - 1);

  state_t                state_q;
  logic [START_BITS-1:0] base_q;
  logic [ADDR_BITS-1:0]  idx_q;
  logic [WW-1:0]         wd_q;
  logic                  go_s, home_s, inc_s, dec_s;
  logic                  clr_inc, clr_dec;

  // Repeat timers run only while browsing and only for a lone inc or dec.
  assign clr_inc = (state_q != BROWSE) | btn_dec;
  assign clr_dec = (state_q != BROWSE) | btn_inc;

  press_repeat #(.REPEAT_EN(1'b0), .HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES))
    u_go   (.clk(clk), .reset(reset), .lvl_i(btn_go),   .clr_i(1'b0),    .step_o(go_s));
  press_repeat #(.REPEAT_EN(1'b0), .HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES))
    u_home (.clk(clk), .reset(reset), .lvl_i(btn_home), .clr_i(1'b0),    .step_o(home_s));
  press_repeat #(.REPEAT_EN(1'b1), .HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES))
    u_inc  (.clk(clk), .reset(reset), .lvl_i(btn_inc),  .clr_i(clr_inc), .step_o(inc_s));
  press_repeat #(.REPEAT_EN(1'b1), .HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES))
    u_dec  (.clk(clk), .reset(reset), .lvl_i(btn_dec),  .clr_i(clr_dec), .step_o(dec_s));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      base_q   <= '0;
      idx_q    <= '0;
      wd_q     <= '0;
      range_go <= 1'b0;
      busy     <= 1'b0;
      ready    <= 1'b0;
      error    <= 1'b0;
    end else begin
      range_go <= 1'b0;
      case (state_q)
        IDLE: begin
          if (go_s) begin
            base_q   <= sw_start;
            idx_q    <= '0;
            error    <= 1'b0;
            range_go <= 1'b1;
            state_q  <= LAUNCH;
          end
        end
        LAUNCH: begin
          busy    <= 1'b1;
          wd_q    <= '0;
          state_q <= BUSY;
        end
        BUSY: begin
          // Completion takes precedence over an expiring watchdog.
          if (range_done) begin
            busy    <= 1'b0;
            ready   <= 1'b1;
            idx_q   <= '0;
            state_q <= BROWSE;
          end else if (wd_q == WW'(TIMEOUT_CYCLES - 1)) begin
            busy    <= 1'b0;
            error   <= 1'b1;
            state_q <= IDLE;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        BROWSE: begin
          if (go_s) begin
            base_q   <= sw_start;
            idx_q    <= '0;
            error    <= 1'b0;
            ready    <= 1'b0;
            range_go <= 1'b1;
            state_q  <= LAUNCH;
          end else if (home_s) begin
            idx_q <= '0;
          end else if (inc_s && !dec_s) begin
            if (idx_q != IDX_MAX) idx_q <= idx_q + 1'b1;
          end else if (dec_s && !inc_s) begin
            if (idx_q != '0) idx_q <= idx_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign range_start = base_q;
  assign range_addr  = idx_q;
  assign disp_n      = base_q + START_BITS'(idx_q);
endmodule

// File: tb/tb_range_ctrl.sv
module tb_range_ctrl;
  localparam int RW = 8, AB = 3, SB = 32, HC = 10, RC = 4, TO = 50;

  logic          clk = 1'b0, reset = 1'b1;
  logic [SB-1:0] sw_start = '0;
  logic          btn_go = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0, btn_home = 1'b0;
  logic          range_done = 1'b0;
  logic          range_go, busy, ready, error;
  logic [SB-1:0] range_start, disp_n;
  logic [AB-1:0] range_addr;

  always #5 clk = ~clk;

  range_ctrl #(.RAM_WORDS(RW), .ADDR_BITS(AB), .START_BITS(SB), .HOLD_CYCLES(HC),
               .REPEAT_CYCLES(RC), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .sw_start(sw_start), .btn_go(btn_go), .btn_inc(btn_inc),
    .btn_dec(btn_dec), .btn_home(btn_home), .range_done(range_done), .range_go(range_go),
    .range_start(range_start), .range_addr(range_addr), .disp_n(disp_n), .busy(busy),
    .ready(ready), .error(error));

  int n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Behavioural model: mode 0 idle, 1 launch, 2 busy, 3 browse.
  int            m_mode = 0, m_idx = 0, m_wd = 0, h_inc = 0, h_dec = 0;
  logic [SB-1:0] m_base = '0;
  bit            m_go, m_busy, m_ready, m_err, started;
  bit            p_go, p_home, p_inc, p_dec;

  task automatic m_launch();
    m_base = sw_start; m_idx = 0; m_err = 0; m_ready = 0; m_go = 1; m_mode = 1;
  endtask

  always @(posedge clk) begin
    bit gs, hs, is, ds, brw;
    if (reset) begin
      m_mode = 0; m_base = '0; m_idx = 0; m_wd = 0; m_go = 0; m_busy = 0;
      m_ready = 0; m_err = 0; h_inc = 0; h_dec = 0;
      p_go = 1; p_home = 1; p_inc = 1; p_dec = 1; started = 1;
    end else begin
      gs = btn_go & !p_go;   hs = btn_home & !p_home;
      is = btn_inc & !p_inc; ds = btn_dec & !p_dec;
      brw = (m_mode == 3);
`ifdef RANGE_CTRL_AUTO_REPEAT_EN
      // A lone held button steps after HC held cycles, then every RC.
      if (brw && btn_inc && !btn_dec && h_inc >= HC && (h_inc - HC) % RC == 0) is = 1;
      if (brw && btn_dec && !btn_inc && h_dec >= HC && (h_dec - HC) % RC == 0) ds = 1;
`endif
      h_inc = (brw && btn_inc && !btn_dec) ? h_inc + 1 : 0;
      h_dec = (brw && btn_dec && !btn_inc) ? h_dec + 1 : 0;
      p_go = btn_go; p_home = btn_home; p_inc = btn_inc; p_dec = btn_dec;
      m_go = 0;
      case (m_mode)
        0: if (gs) m_launch();
        1: begin m_mode = 2; m_busy = 1; m_wd = 0; end
        2: if (range_done) begin
             m_mode = 3; m_busy = 0; m_ready = 1; m_idx = 0;
           end else if (m_wd == TO - 1) begin
             m_mode = 0; m_busy = 0; m_err = 1;
           end else m_wd++;
        default: if (gs) m_launch();
                 else if (hs) m_idx = 0;
                 else if (is && !ds) m_idx = (m_idx == RW - 1) ? m_idx : m_idx + 1;
                 else if (ds && !is) m_idx = (m_idx == 0) ? 0 : m_idx - 1;
      endcase
    end
  end

  // Every-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      n_vec++;
      if (range_go !== m_go || busy !== m_busy || ready !== m_ready || error !== m_err ||
          range_start !== m_base || range_addr !== AB'(m_idx) ||
          disp_n !== SB'(m_base + SB'(m_idx))) begin
        n_err++;
        $display("FAIL cycle t=%0t: go=%b busy=%b ready=%b err=%b start=%0d addr=%0d disp=%0d want go=%b busy=%b ready=%b err=%b start=%0d addr=%0d disp=%0d",
                 $time, range_go, busy, ready, error, range_start, range_addr, disp_n,
                 m_go, m_busy, m_ready, m_err, m_base, m_idx, SB'(m_base + SB'(m_idx)));
      end
    end
  end

  int bc = 0, gc = 0;
  logic [SB-1:0] g_start = '0;

  task automatic tick();
    @(posedge clk); #1;
    if (busy === 1'b1) bc++;
    if (range_go === 1'b1) begin gc++; g_start = range_start; end
  endtask

  task automatic press_inc(); btn_inc = 1; tick(); btn_inc = 0; tick(); endtask
  task automatic press_dec(); btn_dec = 1; tick(); btn_dec = 0; tick(); endtask
  task automatic press_go();  btn_go  = 1; tick(); btn_go  = 0; tick(); endtask

  initial begin
    // go held through reset must not launch until released and re-pressed.
    reset = 1; btn_go = 1;
    repeat (3) tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_addr", 64'(range_addr), 64'd0);
    reset = 0; gc = 0;
    repeat (5) tick();
    chk("held_go_no_launch", 64'(gc), 64'd0);
    btn_go = 0; tick();

    // Launch with 27, done on the 20th BUSY cycle.
    sw_start = 27; gc = 0; bc = 0;
    btn_go = 1; tick(); btn_go = 0; tick();
    repeat (19) tick();
    range_done = 1; tick(); range_done = 0;
    chk("go_pulses", 64'(gc), 64'd1);
    chk("go_start", 64'(g_start), 64'd27);
    chk("busy_cycles", 64'(bc), 64'd20);
    chk("done_ready", 64'(ready), 64'd1);
    chk("done_addr", 64'(range_addr), 64'd0);
    chk("done_disp", 64'(disp_n), 64'd27);

    repeat (9) press_inc();
    chk("inc_sat_addr", 64'(range_addr), 64'd7);
    chk("inc_sat_disp", 64'(disp_n), 64'd34);
    repeat (9) press_dec();
    chk("dec_sat_addr", 64'(range_addr), 64'd0);

    press_inc();
    btn_inc = 1; btn_dec = 1; tick(); btn_inc = 0; btn_dec = 0; tick();
    chk("inc_dec_both", 64'(range_addr), 64'd1);

    // Held inc for 31 sampled edges.
    btn_home = 1; tick(); btn_home = 0; tick();
    chk("home", 64'(range_addr), 64'd0);
    btn_inc = 1; repeat (31) tick(); btn_inc = 0; tick();
`ifdef RANGE_CTRL_AUTO_REPEAT_EN
    chk("hold_repeat", 64'(range_addr), 64'd7);
`else
    chk("hold_single", 64'(range_addr), 64'd1);
`endif

    // Relaunch from BROWSE, go during BUSY ignored, watchdog expiry.
    sw_start = 100; gc = 0;
    press_go();
    press_go();
    repeat (60) tick();
    chk("busy_go_ignored", 64'(gc), 64'd1);
    chk("to_error", 64'(error), 64'd1);
    chk("to_ready", 64'(ready), 64'd0);
    chk("to_busy", 64'(busy), 64'd0);
    btn_go = 1; tick(); btn_go = 0;
    chk("go_clears_err", 64'(error), 64'd0);
    tick(); tick();
    range_done = 1; tick(); range_done = 0; tick();

    // Reset in BUSY, then a late done.
    press_go(); tick();
    reset = 1; tick(); reset = 0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_start", 64'(range_start), 64'd0);
    chk("midrst_err", 64'(error), 64'd0);
    range_done = 1; tick(); range_done = 0; tick();
    chk("late_done", 64'(ready), 64'd0);

    // Randomized phase against the model.
    for (int i = 0; i < 1500; i++) begin
      sw_start   = $urandom;
      btn_go     = ($urandom_range(0, 39) == 0);
      btn_home   = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 7) == 0) btn_inc = ~btn_inc;
      if ($urandom_range(0, 9) == 0) btn_dec = ~btn_dec;
      range_done = ($urandom_range(0, 24) == 0);
      reset      = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 0; btn_go = 0; btn_inc = 0; btn_dec = 0; btn_home = 0; range_done = 0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
